// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM memory-stage controller.
package sram_controller_pkg;

  localparam int unsigned DATA_BASE   = 1024;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses with wait states.
// ready is low while an access is in flight so the pipeline can freeze on it.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned DATA_BASE   = sram_controller_pkg::DATA_BASE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       rd_en,
  input  logic                                       wr_en,
  input  logic [31:0]                                address,
  input  logic [31:0]                                write_data,
  output logic [31:0]                                read_data,
  output logic                                       ready,
  output logic [sram_controller_pkg::SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [sram_controller_pkg::SRAM_DATA_W-1:0] sram_dq,
  output logic                                       sram_we_n
);

  import sram_controller_pkg::*;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] read_data_q;
  logic        capture_lo, capture_hi;

  logic [31:0] offset;
  logic [16:0] word;
  logic        drive_en;
  logic [15:0] drive_data;

  // Byte address relative to the data segment; the byte-in-word bits are dropped.
  assign offset = address - 32'(DATA_BASE);
  assign word   = offset[18:2];

  // State, wait counter and latched operation type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
    end
  end

  // Next-state logic; each half is held for WAIT_CYCLES cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    capture_lo = 1'b0;
    capture_hi = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_en || rd_en) begin
          state_d    = StLo;
          cnt_d      = 4'd0;
          // A simultaneous read and write is treated as a write.
          is_write_d = wr_en;
        end
      end
      StLo: begin
        if (cnt_q == LastCnt) begin
          state_d    = StHi;
          cnt_d      = 4'd0;
          capture_lo = ~is_write_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHi: begin
        if (cnt_q == LastCnt) begin
          state_d    = StDone;
          cnt_d      = 4'd0;
          capture_hi = ~is_write_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        // Never restarts from here even if the request is still asserted.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load result register; reset discards any partially captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q <= 32'd0;
    end else begin
      if (capture_lo) read_data_q[15:0]  <= sram_dq;
      if (capture_hi) read_data_q[31:16] <= sram_dq;
    end
  end

  // SRAM bus and handshake outputs.
  always_comb begin
    ready      = (state_q == StDone) || ((state_q == StIdle) && !rd_en && !wr_en);
    sram_we_n  = 1'b1;
    drive_en   = 1'b0;
    drive_data = write_data[15:0];
    sram_addr  = {word, 1'b0};
    unique case (state_q)
      StLo: begin
        sram_we_n  = ~is_write_q;
        drive_en   = is_write_q;
        drive_data = write_data[15:0];
      end
      StHi: begin
        sram_addr  = {word, 1'b1};
        sram_we_n  = ~is_write_q;
        drive_en   = is_write_q;
        drive_data = write_data[31:16];
      end
      default: begin
      end
    endcase
  end

  assign sram_dq   = drive_en ? drive_data : 16'hzzzz;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: default build (WAIT_CYCLES=5) and a WAIT_CYCLES=1 build,
// each with its own behavioural 256K x 16 SRAM.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;

  // Default build.
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_we_n;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;

  // WAIT_CYCLES = 1 build.
  logic        rd_en_w1, wr_en_w1;
  logic [31:0] address_w1, write_data_w1, read_data_w1;
  logic        ready_w1, sram_we_n_w1;
  logic [17:0] sram_addr_w1;
  wire  [15:0] sram_dq_w1;

  logic [15:0] mem    [0:262143];
  logic [15:0] mem_w1 [0:262143];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq    (sram_dq),
    .sram_we_n  (sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut_w1 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en_w1),
    .wr_en      (wr_en_w1),
    .address    (address_w1),
    .write_data (write_data_w1),
    .read_data  (read_data_w1),
    .ready      (ready_w1),
    .sram_addr  (sram_addr_w1),
    .sram_dq    (sram_dq_w1),
    .sram_we_n  (sram_we_n_w1)
  );

  // SRAM models: combinational read while we_n is high, write on clk while low.
  assign sram_dq    = sram_we_n    ? mem[sram_addr]       : 16'hzzzz;
  assign sram_dq_w1 = sram_we_n_w1 ? mem_w1[sram_addr_w1] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n)    mem[sram_addr]       <= sram_dq;
    if (!sram_we_n_w1) mem_w1[sram_addr_w1] <= sram_dq_w1;
  end

  // Issue one request on the default build and count ready-low cycles until
  // the DONE cycle; returns at posedge+1 after DONE with the request still driven.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, output int lows,
                        output logic [31:0] rdata);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    lows = 0; rdata = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        rdata = read_data;
        break;
      end
      lows++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op_w1(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, output int lows,
                           output logic [31:0] rdata);
    wr_en_w1 = wr; rd_en_w1 = rd; address_w1 = addr; write_data_w1 = data;
    lows = 0; rdata = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_w1) begin
        rdata = read_data_w1;
        break;
      end
      lows++;
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = 32'd1028; write_data = 32'd0;
    rd_en_w1 = 1'b0; wr_en_w1 = 1'b0; address_w1 = 32'd1024; write_data_w1 = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (read_data !== 32'd0) $display("FAIL reset_read_data got %h want 0", read_data);
    else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready);
    else pass_cnt++;
    total_cnt++;
    if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", sram_we_n);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  // Bus must be undriven by the DUT: the value seen is only the model's read data.
  task automatic test_idle();
    write_data = 32'hFFFF_FFFF;
    address    = 32'd1100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b1) $display("FAIL idle_ready cyc %0d got %b want 1", i, ready);
      else pass_cnt++;
      total_cnt++;
      if (sram_we_n !== 1'b1) $display("FAIL idle_we_n cyc %0d got %b want 1", i, sram_we_n);
      else pass_cnt++;
      total_cnt++;
      if (sram_dq !== mem[sram_addr])
        $display("FAIL idle_dq cyc %0d got %h want model %h", i, sram_dq, mem[sram_addr]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int lows;
    logic [31:0] rd;
    run_op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, lows, rd);
    go_idle();
    total_cnt++;
    if (lows !== 11) $display("FAIL store_stall got %0d want 11", lows);
    else pass_cnt++;
    total_cnt++;
    if (mem[2] !== 16'hBEEF) $display("FAIL store_lo got %h want beef", mem[2]);
    else pass_cnt++;
    total_cnt++;
    if (mem[3] !== 16'hDEAD) $display("FAIL store_hi got %h want dead", mem[3]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL store_after_ready got %b want 1", ready);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    int lows;
    logic [31:0] rd;
    run_op(1'b0, 1'b1, 32'd1028, 32'h0, lows, rd);
    go_idle();
    total_cnt++;
    if (lows !== 11) $display("FAIL load_stall got %0d want 11", lows);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL load_data got %h want deadbeef", rd);
    else pass_cnt++;
    // A store must not disturb the held load result.
    run_op(1'b1, 1'b0, 32'd1040, 32'hCAFE_F00D, lows, rd);
    go_idle();
    @(negedge clk);
    total_cnt++;
    if (read_data !== 32'hDEAD_BEEF) $display("FAIL load_hold got %h want deadbeef", read_data);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lows_a, lows_b;
    logic [31:0] rd_a, rd_b;
    run_op(1'b1, 1'b0, 32'd1032, 32'h1234_5678, lows_a, rd_a);
    run_op(1'b0, 1'b1, 32'd1032, 32'h0, lows_b, rd_b);
    go_idle();
    total_cnt++;
    if (lows_a !== 11) $display("FAIL b2b_store_stall got %0d want 11", lows_a);
    else pass_cnt++;
    total_cnt++;
    if (lows_b !== 11) $display("FAIL b2b_load_stall got %0d want 11", lows_b);
    else pass_cnt++;
    total_cnt++;
    if (rd_b !== 32'h1234_5678) $display("FAIL b2b_load_data got %h want 12345678", rd_b);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    // Cycle 0: request presented.
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'hAAAA_5555;
    repeat (3) begin
      @(posedge clk); #1;
    end
    // Cycle 3: low half is being written.
    @(negedge clk);
    total_cnt++;
    if (sram_we_n !== 1'b0) $display("FAIL midstore_we_n got %b want 0", sram_we_n);
    else pass_cnt++;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (sram_we_n !== 1'b1) $display("FAIL abort_we_n got %b want 1", sram_we_n);
    else pass_cnt++;
    total_cnt++;
    if (read_data !== 32'd0) $display("FAIL abort_read_data got %h want 0", read_data);
    else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL abort_ready got %b want 1", ready);
    else pass_cnt++;
    total_cnt++;
    if (sram_dq !== mem[sram_addr])
      $display("FAIL abort_dq got %h want model %h", sram_dq, mem[sram_addr]);
    else pass_cnt++;
    // FSM must be in IDLE: a new request stalls for the full 11 cycles.
    @(posedge clk); #1;
    begin
      int lows;
      logic [31:0] rd;
      run_op(1'b0, 1'b1, 32'd1028, 32'h0, lows, rd);
      go_idle();
      total_cnt++;
      if (lows !== 11 || rd !== 32'hDEAD_BEEF)
        $display("FAIL abort_then_load got %0d/%h want 11/deadbeef", lows, rd);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_one();
    int lows;
    logic [31:0] rd;
    run_op_w1(1'b1, 1'b0, 32'd1024, 32'h8765_4321, lows, rd);
    wr_en_w1 = 1'b0;
    total_cnt++;
    if (lows !== 3) $display("FAIL w1_store_stall got %0d want 3", lows);
    else pass_cnt++;
    total_cnt++;
    if (mem_w1[0] !== 16'h4321 || mem_w1[1] !== 16'h8765)
      $display("FAIL w1_store_mem got %h_%h want 8765_4321", mem_w1[1], mem_w1[0]);
    else pass_cnt++;
    run_op_w1(1'b0, 1'b1, 32'd1024, 32'h0, lows, rd);
    rd_en_w1 = 1'b0;
    total_cnt++;
    if (lows !== 3) $display("FAIL w1_load_stall got %0d want 3", lows);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h8765_4321) $display("FAIL w1_load_data got %h want 87654321", rd);
    else pass_cnt++;
    // Both enables high behaves as a write.
    run_op_w1(1'b1, 1'b1, 32'd1028, 32'h0F0F_A5A5, lows, rd);
    wr_en_w1 = 1'b0; rd_en_w1 = 1'b0;
    total_cnt++;
    if (mem_w1[2] !== 16'hA5A5 || mem_w1[3] !== 16'h0F0F || read_data_w1 !== 32'h8765_4321)
      $display("FAIL w1_rdwr_is_write got %h_%h rd %h want 0f0f_a5a5 rd 87654321",
               mem_w1[3], mem_w1[2], read_data_w1);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_store();
    test_wait_one();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
